// File: rtl/shared_mem_store_port.sv
// Store endpoint between core writeback and the shared-memory arbiter: buffers byte-masked stores in a
// DEPTH-entry FIFO and drains them in order over req/gnt. Define SHARED_MEM_RMW_EN for read-merge-write.
module shared_mem_store_port #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_mask,
  input  logic [31:0]            in_addr,
  input  logic [31:0]            in_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  // Handshakes: a store transfers on a cycle where in_valid & in_ready are both high (in_ready depends
  // only on count, never on the pop this cycle); a memory access transfers when mem_req & mem_gnt are
  // both high, and mem_req plus every mem_* field stay constant from assertion until that cycle.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t        state;

  logic [29:0]   fifo_addr [DEPTH];
  logic [3:0]    fifo_mask [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_left;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic [29:0]   nh_addr;
  logic [3:0]    nh_mask;
  logic [31:0]   nh_data;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready & (|in_mask);
  assign pop      = (state == S_WRITE) & mem_gnt;
  assign busy     = (count != '0) | (state != S_IDLE);

  // Head entry as it will be after this edge; when the FIFO drains to empty the incoming store
  // becomes the head, so an idle port can issue it on the very next cycle.
  always_comb begin
    rd_ptr_nxt = rd_ptr + PW'(pop);
    count_left = count - CW'(pop);
    count_nxt  = count_left + CW'(push);
    if (count_left == '0) begin
      nh_addr = in_addr[31:2];
      nh_mask = in_mask;
      nh_data = in_data;
    end else begin
      nh_addr = fifo_addr[rd_ptr_nxt];
      nh_mask = fifo_mask[rd_ptr_nxt];
      nh_data = fifo_data[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_mask[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= in_addr[31:2];
        fifo_mask[wr_ptr] <= in_mask;
        fifo_data[wr_ptr] <= in_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

`ifdef SHARED_MEM_RMW_EN
  logic [31:0] merge_word;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^in_addr[1:0];

  // Lanes the store covers come from the head entry, the rest keep the memory's current contents.
  always_comb begin
    merge_word = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fifo_mask[rd_ptr][i]) begin
        merge_word[8*i +: 8] = fifo_data[rd_ptr][8*i +: 8];
      end
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{in_addr[1:0], mem_rvalid, mem_rdata};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        S_IDLE, S_WRITE: begin
          if ((state == S_IDLE) || mem_gnt) begin
            if (count_nxt != '0) begin
              mem_req  <= 1'b1;
              mem_addr <= {nh_addr, 2'b00};
`ifdef SHARED_MEM_RMW_EN
              if (nh_mask == 4'hF) begin
                state     <= S_WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= nh_data;
                mem_be    <= 4'hF;
              end else begin
                state     <= S_READ;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                mem_be    <= '0;
              end
`else
              state     <= S_WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= nh_data;
              mem_be    <= nh_mask;
`endif
            end else begin
              state     <= S_IDLE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_be    <= '0;
            end
          end
        end
`ifdef SHARED_MEM_RMW_EN
        S_READ: begin
          if (mem_gnt) begin
            state   <= S_WAIT;
            mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state     <= S_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= merge_word;
            mem_be    <= 4'hF;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_be    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem_store_port.sv
// Bench for shared_mem_store_port: directed scenarios then random stores, checked against an in-order
// queue of expected memory writes (with a memory image for the SHARED_MEM_RMW_EN build).
module tb_shared_mem_store_port;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_mask;
  logic [31:0]   in_addr;
  logic [31:0]   in_data;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic [CW-1:0] count;

  shared_mem_store_port #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .count      (count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [67:0] exp_q[$];      // {word address, byte enables, write data} in expected order
  int          gnt_mode;      // 0 = never grant, 1 = always grant, 2 = random
  logic        acc;
  logic        held;
  logic [69:0] held_word;
  int          wr_cnt;
  int          req_cyc;
  logic [67:0] last_wr;
`ifdef SHARED_MEM_RMW_EN
  logic [31:0] mem_model [logic [29:0]];
  int          rd_wait;
  logic [31:0] rd_word;
  int          rd_cnt;
  logic        read_done;

  function automatic logic [31:0] mem_peek(input logic [29:0] w);
    return mem_model.exists(w) ? mem_model[w] : ({w[13:0], w[17:0]} ^ 32'hA5A5_5A5A);
  endfunction
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory-side responder: grant policy and read returns
  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0:       mem_gnt = 1'b0;
      1:       mem_gnt = 1'b1;
      default: mem_gnt = 1'($urandom_range(0, 1));
    endcase
`ifdef SHARED_MEM_RMW_EN
    if (rd_wait > 0) begin
      rd_wait--;
      mem_rvalid = (rd_wait == 0);
      mem_rdata  = (rd_wait == 0) ? rd_word : $urandom;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
`else
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
`endif
  end

  // scoreboard: compare DUT state and memory traffic against the expected queue
  always @(negedge clk) begin
    logic [67:0] e;
    logic        ready_m;
`ifdef SHARED_MEM_RMW_EN
    logic [31:0] exp_w;
    logic [31:0] old_w;
`endif
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
      acc  = 1'b0;
`ifdef SHARED_MEM_RMW_EN
      rd_wait   = 0;
      read_done = 1'b0;
`endif
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_be", mem_be, 4'h0);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
    end else begin
      ready_m = (exp_q.size() < DEPTH);
      req_cyc += int'(mem_req);
      check("count", count, exp_q.size());
      check("in_ready", in_ready, ready_m);
      check("busy", busy, exp_q.size() != 0);
`ifndef SHARED_MEM_RMW_EN
      check("mem_req", mem_req, exp_q.size() != 0);
`endif
      if (held) check("held_stable", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, held_word);
      held      = mem_req && !mem_gnt;
      held_word = {mem_req, mem_we, mem_addr, mem_be, mem_wdata};
      if (mem_req && mem_gnt) begin
        check("req_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
`ifdef SHARED_MEM_RMW_EN
          if (!mem_we) begin
            check("rd_only_partial", e[35:32] != 4'hF, 1'b1);
            check("rd_addr", mem_addr, e[67:36]);
            rd_wait   = $urandom_range(1, 3);
            rd_word   = mem_peek(e[67:38]);
            read_done = 1'b1;
            rd_cnt++;
          end else begin
            old_w = mem_peek(e[67:38]);
            for (int i = 0; i < 4; i++)
              exp_w[8*i +: 8] = e[32+i] ? e[8*i +: 8] : old_w[8*i +: 8];
            if (e[35:32] != 4'hF) check("rmw_read_first", read_done, 1'b1);
            check("wr_word", {mem_addr, mem_be, mem_wdata}, {e[67:36], 4'hF, exp_w});
            mem_model[e[67:38]] = exp_w;
            read_done = 1'b0;
            wr_cnt++;
            last_wr = {mem_addr, mem_be, mem_wdata};
            void'(exp_q.pop_front());
          end
`else
          check("mem_we", mem_we, 1'b1);
          check("wr_word", {mem_addr, mem_be, mem_wdata}, e);
          wr_cnt++;
          last_wr = {mem_addr, mem_be, mem_wdata};
          void'(exp_q.pop_front());
`endif
        end
      end
      acc = in_valid && ready_m;
      if (acc && (in_mask != 4'h0)) exp_q.push_back({in_addr[31:2], 2'b00, in_mask, in_data});
    end
  end

  // driver tasks (called at posedge+1, return at posedge+1)
  task automatic push(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_mask  = m;
    in_addr  = a;
    in_data  = d;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL push_timeout observed=not_accepted expected=accepted");
    end
    #1;
    in_valid = 1'b0;
    in_mask  = 4'h0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d_pending expected=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int          base;
    int          base_req;
    logic [3:0]  m;
    logic [31:0] a;
    int          sel;
    rst = 1'b1; in_valid = 1'b0; in_mask = 4'h0; in_addr = '0; in_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    gnt_mode = 0; acc = 1'b0; held = 1'b0; wr_cnt = 0; req_cyc = 0; last_wr = '0;
`ifdef SHARED_MEM_RMW_EN
    rd_wait = 0; rd_cnt = 0; read_done = 1'b0; rd_word = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // single store with grant tied high
    gnt_mode = 1;
    base = wr_cnt; base_req = req_cyc;
    push(4'b0011, 32'h1000_0007, 32'h0000_BEEF);
    wait_drain();
    check("single_wr_count", wr_cnt - base, 1);
`ifndef SHARED_MEM_RMW_EN
    check("single_req_cycles", req_cyc - base_req, 1);
    check("single_wr", last_wr, {32'h1000_0004, 4'b0011, 32'h0000_BEEF});
`endif
    check("single_count", count, 0);
    check("single_busy", busy, 1'b0);

    // fill with grant held low, then release
    gnt_mode = 0;
    base = wr_cnt;
    fork
      for (int i = 0; i < 5; i++) push(4'hF, 32'h2000_0000 + 32'(4 * i), $urandom);
      begin
        repeat (6) @(posedge clk);
        #1;
        check("fill_count", count, 4);
        check("fill_in_ready", in_ready, 1'b0);
        gnt_mode = 1;
      end
    join
    wait_drain();
    check("fill_wr_count", wr_cnt - base, 5);

    // zero-mask store: handshake only
    base_req = req_cyc;
    push(4'h0, 32'h3000_0000, 32'hDEAD_BEEF);
    repeat (4) @(posedge clk);
    #1;
    check("mask0_no_req", req_cyc - base_req, 0);
    check("mask0_count", count, 0);

    // concurrent push and pop at count 2 across pointer wrap
    gnt_mode = 0;
    base = wr_cnt;
    push(4'hF, 32'h3100_0000, $urandom);
    push(4'hF, 32'h3100_0004, $urandom);
    gnt_mode = 1;
    for (int i = 0; i < 12; i++) push(4'(i % 15 + 1), 32'h3200_0000 + 32'(4 * i), $urandom);
    wait_drain();
    check("stream_wr_count", wr_cnt - base, 14);

    // reset while a write is held off by the arbiter
    gnt_mode = 0;
    for (int i = 0; i < 3; i++) push(4'hF, 32'h3300_0000 + 32'(4 * i), $urandom);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_count", count, 0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gnt_mode = 1;
    base = wr_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_write", wr_cnt - base, 0);

`ifdef SHARED_MEM_RMW_EN
    // partial store merges with memory contents; a full-mask store skips the read
    mem_model[30'h1000_0004] = 32'h1122_3344;
    push(4'b0100, 32'h4000_0010, 32'h00AA_0000);
    wait_drain();
    check("rmw_example", last_wr, {32'h4000_0010, 4'hF, 32'h11AA_3344});
    base = rd_cnt;
    push(4'hF, 32'h4000_0020, 32'h1234_5678);
    wait_drain();
    check("full_mask_no_read", rd_cnt - base, 0);
`endif

    // random stores under random grant
    gnt_mode = 2;
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      m   = (sel == 0) ? 4'h0 : (sel < 4) ? 4'hF : 4'($urandom_range(1, 15));
      a   = 32'h5000_0000 | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
      push(m, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    gnt_mode = 1;
    wait_drain();
    check("final_count", count, 0);
    check("final_busy", busy, 1'b0);
    check("final_mem_req", mem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
